// File: rtl/mc_main_ctrl_pkg.sv
// mc_main_ctrl_pkg
// Shared definitions for the multicycle MIPS main controller:
//   - opcode constants for the supported instruction subset
//   - ALUOp encodings consumed by ALU_Ctrl
//   - FSM state encodings (also visible on state_o)
//   - ctrl_word_t, the datapath control word produced each cycle
package mc_main_ctrl_pkg;

    // Opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_J     = 6'b000010;

    // ALUOp encodings shared with ALU_Ctrl
    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_FUNCT = 3'b010;
    localparam logic [2:0] ALUOP_SLT   = 3'b011;

    // FSM states
    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_REXEC  = 4'd6;
    localparam logic [3:0] S_RWB    = 4'd7;
    localparam logic [3:0] S_BEQ    = 4'd8;
    localparam logic [3:0] S_IEXEC  = 4'd9;
    localparam logic [3:0] S_IWB    = 4'd10;
    localparam logic [3:0] S_JUMP   = 4'd11;

    // Mux selects
    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic [2:0] alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
    } ctrl_word_t;

    function automatic logic is_legal_op(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_ADDI) || (op == OP_SLTI) ||
               (op == OP_BEQ)   || (op == OP_LW)   || (op == OP_SW)   ||
               (op == OP_J);
    endfunction

endpackage

// File: rtl/mc_main_ctrl_if.sv
// mc_main_ctrl_if
// Controller <-> datapath/memory bundle.
//   opcode_i, mem_ready_i : datapath/memory -> controller
//   all *_o signals        : controller -> datapath/memory/ALU_Ctrl
// master = controller side, slave = datapath side.
interface mc_main_ctrl_if;
    logic [5:0] opcode_i;
    logic       mem_ready_i;
    logic [2:0] ALUOp_o;
    logic       ALUSrcA_o;
    logic [1:0] ALUSrcB_o;
    logic       IorD_o;
    logic       MemRead_o;
    logic       MemWrite_o;
    logic       IRWrite_o;
    logic       PCWrite_o;
    logic       PCWriteCond_o;
    logic [1:0] PCSource_o;
    logic       RegDst_o;
    logic       MemtoReg_o;
    logic       RegWrite_o;

    modport master (
        input  opcode_i, mem_ready_i,
        output ALUOp_o, ALUSrcA_o, ALUSrcB_o, IorD_o, MemRead_o, MemWrite_o,
               IRWrite_o, PCWrite_o, PCWriteCond_o, PCSource_o, RegDst_o,
               MemtoReg_o, RegWrite_o
    );

    modport slave (
        output opcode_i, mem_ready_i,
        input  ALUOp_o, ALUSrcA_o, ALUSrcB_o, IorD_o, MemRead_o, MemWrite_o,
               IRWrite_o, PCWrite_o, PCWriteCond_o, PCSource_o, RegDst_o,
               MemtoReg_o, RegWrite_o
    );
endinterface

// File: rtl/mc_ctrl_decode.sv
// mc_ctrl_decode
// Purely combinational control-word decode for the main controller.
//   state_i     : current FSM state
//   opcode_i    : instruction opcode (selects slt vs add in IEXEC)
//   mem_ready_i : gates IRWrite/PCWrite in FETCH
//   ctrl_o      : datapath control word; anything not set for a state is 0
module mc_ctrl_decode
    import mc_main_ctrl_pkg::*;
(
    input  logic [3:0] state_i,
    input  logic [5:0] opcode_i,
    input  logic       mem_ready_i,
    output ctrl_word_t ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        unique case (state_i)
            S_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.alu_src_b = SRCB_FOUR;
                // PC+4 and IR only commit on the cycle memory returns data
                ctrl_o.ir_write  = mem_ready_i;
                ctrl_o.pc_write  = mem_ready_i;
            end
            S_DECODE: begin
                // speculative branch target into ALUOut
                ctrl_o.alu_src_b = SRCB_IMMSH;
            end
            S_MEMADR: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.reg_write  = 1'b1;
            end
            S_MEMWR: begin
                ctrl_o.mem_write = 1'b1;
                ctrl_o.i_or_d    = 1'b1;
            end
            S_REXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_op    = ALUOP_FUNCT;
            end
            S_RWB: begin
                ctrl_o.reg_dst   = 1'b1;
                ctrl_o.reg_write = 1'b1;
            end
            S_BEQ: begin
                ctrl_o.alu_src_a     = 1'b1;
                ctrl_o.alu_op        = ALUOP_SUB;
                ctrl_o.pc_write_cond = 1'b1;
                ctrl_o.pc_source     = PCSRC_ALUOUT;
            end
            S_IEXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = (opcode_i == OP_SLTI) ? ALUOP_SLT : ALUOP_ADD;
            end
            S_IWB: begin
                ctrl_o.reg_write = 1'b1;
            end
            S_JUMP: begin
                ctrl_o.pc_write  = 1'b1;
                ctrl_o.pc_source = PCSRC_JUMP;
            end
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/mc_main_ctrl.sv
// mc_main_ctrl
// Main control FSM of the multicycle MIPS datapath.
//   clk_i     : clock, rising edge
//   rst_i     : asynchronous active-low reset (FSM -> FETCH, illegal cleared)
//   bus       : mc_main_ctrl_if.master (opcode/mem_ready in, control word out)
//   state_o   : current state (debug)
//   illegal_o : sticky, set when DECODE sees an unsupported opcode
module mc_main_ctrl
    import mc_main_ctrl_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_i,
    mc_main_ctrl_if.master      bus,
    output logic [3:0]          state_o,
    output logic                illegal_o
);

    logic [3:0] state_q, state_d;
    logic       illegal_q, illegal_d;
    ctrl_word_t ctrl;

    always_comb begin
        state_d   = S_FETCH;
        illegal_d = illegal_q;
        unique case (state_q)
            S_FETCH:  state_d = bus.mem_ready_i ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (bus.opcode_i == OP_LW || bus.opcode_i == OP_SW)
                    state_d = S_MEMADR;
                else if (bus.opcode_i == OP_RTYPE)
                    state_d = S_REXEC;
                else if (bus.opcode_i == OP_BEQ)
                    state_d = S_BEQ;
                else if (bus.opcode_i == OP_ADDI || bus.opcode_i == OP_SLTI)
                    state_d = S_IEXEC;
                else if (bus.opcode_i == OP_J)
                    state_d = S_JUMP;
                else
                    state_d = S_FETCH;
                if (!is_legal_op(bus.opcode_i))
                    illegal_d = 1'b1;
            end
            // only lw/sw reach MEMADR, so anything not lw is treated as sw
            S_MEMADR: state_d = (bus.opcode_i == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = bus.mem_ready_i ? S_MEMWB : S_MEMRD;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  state_d = bus.mem_ready_i ? S_FETCH : S_MEMWR;
            S_REXEC:  state_d = S_RWB;
            S_RWB:    state_d = S_FETCH;
            S_BEQ:    state_d = S_FETCH;
            S_IEXEC:  state_d = S_IWB;
            S_IWB:    state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    mc_ctrl_decode u_decode (
        .state_i     (state_q),
        .opcode_i    (bus.opcode_i),
        .mem_ready_i (bus.mem_ready_i),
        .ctrl_o      (ctrl)
    );

    assign bus.ALUOp_o       = ctrl.alu_op;
    assign bus.ALUSrcA_o     = ctrl.alu_src_a;
    assign bus.ALUSrcB_o     = ctrl.alu_src_b;
    assign bus.IorD_o        = ctrl.i_or_d;
    assign bus.MemRead_o     = ctrl.mem_read;
    assign bus.MemWrite_o    = ctrl.mem_write;
    assign bus.IRWrite_o     = ctrl.ir_write;
    assign bus.PCWrite_o     = ctrl.pc_write;
    assign bus.PCWriteCond_o = ctrl.pc_write_cond;
    assign bus.PCSource_o    = ctrl.pc_source;
    assign bus.RegDst_o      = ctrl.reg_dst;
    assign bus.MemtoReg_o    = ctrl.mem_to_reg;
    assign bus.RegWrite_o    = ctrl.reg_write;

    assign state_o   = state_q;
    assign illegal_o = illegal_q;

endmodule

// File: tb/tb_mc_main_ctrl.sv
// tb_mc_main_ctrl
// Scoreboard bench: the driver walks each instruction through its expected
// cycle sequence, pushing one expected observation per cycle; a monitor on the
// falling edge pops and compares against the DUT outputs.
module tb_mc_main_ctrl;

    localparam logic [5:0] T_R = 6'b000000, T_ADDI = 6'b001000, T_SLTI = 6'b001010,
                           T_BEQ = 6'b000100, T_LW = 6'b100011, T_SW = 6'b101011,
                           T_J = 6'b000010;

    logic clk_i = 1'b0;
    logic rst_i;
    logic [3:0] state_o;
    logic illegal_o;

    always #5 clk_i = ~clk_i;

    mc_main_ctrl_if bus();

    mc_main_ctrl dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .bus       (bus),
        .state_o   (state_o),
        .illegal_o (illegal_o)
    );

    typedef struct packed {
        logic [3:0] st;
        logic       ill;
        logic [2:0] aluop;
        logic       srca;
        logic [1:0] srcb;
        logic       iord, mrd, mwr, irw, pcw, pcwc;
        logic [1:0] pcsrc;
        logic       regdst, m2r, regw;
    } obs_t;

    obs_t  exp_q[$];
    string tag_q[$];
    int    checks = 0;
    int    failures = 0;
    bit    ill_m = 1'b0;

    function automatic obs_t sample();
        obs_t a;
        a.st = state_o;          a.ill = illegal_o;
        a.aluop = bus.ALUOp_o;   a.srca = bus.ALUSrcA_o;   a.srcb = bus.ALUSrcB_o;
        a.iord = bus.IorD_o;     a.mrd = bus.MemRead_o;    a.mwr = bus.MemWrite_o;
        a.irw = bus.IRWrite_o;   a.pcw = bus.PCWrite_o;    a.pcwc = bus.PCWriteCond_o;
        a.pcsrc = bus.PCSource_o; a.regdst = bus.RegDst_o; a.m2r = bus.MemtoReg_o;
        a.regw = bus.RegWrite_o;
        return a;
    endfunction

    // monitor
    initial begin
        forever begin
            @(negedge clk_i);
            if (exp_q.size() > 0) begin
                obs_t e, a;
                string t;
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                a = sample();
                checks++;
                if (a !== e) begin
                    failures++;
                    $display("FAIL %s @%0t got st=%0d ctrl=%h required st=%0d ctrl=%h",
                             t, $time, a.st, a, e.st, e);
                end
            end
        end
    end

    function automatic obs_t blank(input logic [3:0] st);
        obs_t e = '0;
        e.st  = st;
        e.ill = ill_m;
        return e;
    endfunction

    // called just after a rising edge; presents inputs for this cycle
    task automatic step(input obs_t e, input bit rdy, input string tag);
        bus.mem_ready_i = rdy;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk_i);
        #1;
    endtask

    function automatic bit rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic reset_hold();
        obs_t e;
        rst_i = 1'b0;
        ill_m = 1'b0;
        e = blank(4'd0);
        e.mrd = 1'b1; e.srcb = 2'b01;
        step(e, 1'b0, "reset");
        rst_i = 1'b1;
    endtask

    // Drives one instruction. With kill set (sw only), stops while waiting in
    // MEMWR so the caller can apply an asynchronous reset mid-access.
    task automatic run_instr(input logic [5:0] op, input int fw, input int mw,
                             input bit kill = 1'b0);
        obs_t e;
        bus.opcode_i = op;
        e = blank(4'd0);
        e.mrd = 1'b1; e.srcb = 2'b01;
        for (int i = 0; i < fw; i++) step(e, 1'b0, "fetch_wait");
        e.irw = 1'b1; e.pcw = 1'b1;
        step(e, 1'b1, "fetch");

        e = blank(4'd1);
        e.srcb = 2'b11;
        step(e, rnd_bit(), "decode");

        case (op)
            T_LW, T_SW: begin
                e = blank(4'd2);
                e.srca = 1'b1; e.srcb = 2'b10;
                step(e, rnd_bit(), "memadr");
                if (op == T_LW) begin
                    e = blank(4'd3);
                    e.mrd = 1'b1; e.iord = 1'b1;
                    for (int i = 0; i < mw; i++) step(e, 1'b0, "memrd_wait");
                    step(e, 1'b1, "memrd");
                    e = blank(4'd4);
                    e.m2r = 1'b1; e.regw = 1'b1;
                    step(e, rnd_bit(), "memwb");
                end else begin
                    e = blank(4'd5);
                    e.mwr = 1'b1; e.iord = 1'b1;
                    for (int i = 0; i < mw; i++) step(e, 1'b0, "memwr_wait");
                    if (!kill) step(e, 1'b1, "memwr");
                end
            end
            T_R: begin
                e = blank(4'd6);
                e.srca = 1'b1; e.aluop = 3'b010;
                step(e, rnd_bit(), "rexec");
                e = blank(4'd7);
                e.regdst = 1'b1; e.regw = 1'b1;
                step(e, rnd_bit(), "rwb");
            end
            T_BEQ: begin
                e = blank(4'd8);
                e.srca = 1'b1; e.aluop = 3'b001; e.pcwc = 1'b1; e.pcsrc = 2'b01;
                step(e, rnd_bit(), "beq");
            end
            T_ADDI, T_SLTI: begin
                e = blank(4'd9);
                e.srca = 1'b1; e.srcb = 2'b10;
                e.aluop = (op == T_SLTI) ? 3'b011 : 3'b000;
                step(e, rnd_bit(), "iexec");
                e = blank(4'd10);
                e.regw = 1'b1;
                step(e, rnd_bit(), "iwb");
            end
            T_J: begin
                e = blank(4'd11);
                e.pcw = 1'b1; e.pcsrc = 2'b10;
                step(e, rnd_bit(), "jump");
            end
            default: ill_m = 1'b1;   // back to FETCH, flag sticks from now on
        endcase
    endtask

    logic [5:0] legal_ops [7];

    initial begin
        legal_ops[0] = T_R;   legal_ops[1] = T_ADDI; legal_ops[2] = T_SLTI;
        legal_ops[3] = T_BEQ; legal_ops[4] = T_LW;   legal_ops[5] = T_SW;
        legal_ops[6] = T_J;

        rst_i = 1'b0;
        bus.mem_ready_i = 1'b0;
        bus.opcode_i = 6'd0;
        @(posedge clk_i);
        #1;
        reset_hold();

        // directed sequence
        run_instr(T_R,    0, 0);
        run_instr(T_LW,   0, 2);
        run_instr(T_SLTI, 0, 0);
        run_instr(T_ADDI, 0, 0);
        run_instr(T_BEQ,  1, 0);
        run_instr(T_J,    0, 0);
        run_instr(6'b111111, 0, 0);
        run_instr(T_R,    0, 0);
        run_instr(T_SW,   0, 2, 1'b1);

        // asynchronous reset while waiting in MEMWR
        bus.mem_ready_i = 1'b0;
        #2;
        rst_i = 1'b0;
        #1;
        checks++;
        if ({state_o, illegal_o, bus.MemWrite_o, bus.MemRead_o} !== {4'd0, 1'b0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL async_reset got st=%0d ill=%b mwr=%b mrd=%b required st=0 ill=0 mwr=0 mrd=1",
                     state_o, illegal_o, bus.MemWrite_o, bus.MemRead_o);
        end
        @(posedge clk_i);
        #1;
        reset_hold();

        // randomized instruction stream
        for (int n = 0; n < 80; n++) begin
            logic [5:0] op;
            if ($urandom_range(0, 9) == 0) begin
                op = 6'($urandom);
                while (op == T_R || op == T_ADDI || op == T_SLTI || op == T_BEQ ||
                       op == T_LW || op == T_SW || op == T_J)
                    op = 6'($urandom);
            end else begin
                op = legal_ops[$urandom_range(0, 6)];
            end
            run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) reset_hold();
        end

        // let the monitor drain, bounded
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk_i);
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain got pending=%0d required pending=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
